// File: rtl/fetch_sequencer.sv
// Fetch/PC-sequencing stage: fetches one instruction, holds it for one execute window,
// then commits the next PC from decoder branch/jump outputs and ALU flags; traps to HALT on bad instructions.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            branch,
    input  logic            jump,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic            stall,
    output logic            halted,
    output logic [1:0]      trap_cause,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

    state_t          state, state_nxt;
    logic            legal, taken, misaligned, commit;
    logic [XLEN-1:0] next_pc, pc_target;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign pc_plus4 = pc + XLEN'(4);
    assign imem_addr = pc;

    // Gating with rst drops the request in the same instant reset is asserted.
    assign imem_req    = (state == FETCH) && !rst;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1101111, 7'b1100111, 7'b0110111: legal = 1'b1;
            7'b1100011: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_target = pc + imm;
        next_pc   = pc_plus4;
        if (jump && is_jalr)
            next_pc = {alu_result[XLEN-1:1], 1'b0};
        else if (jump || (branch && taken))
            next_pc = pc_target;
    end

    assign misaligned = (next_pc[1:0] != 2'b00);
    assign commit     = (state == EXEC) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: if (imem_ready) state_nxt = EXEC;
            EXEC:  if (!stall) state_nxt = (legal && !misaligned) ? FETCH : HALT;
            HALT:  state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr      <= 32'h0000_0013;
            instret    <= '0;
            trap_cause <= 2'b00;
        end else begin
            if (state == FETCH && imem_ready)
                instr <= imem_rdata;
            // Illegal opcode outranks a misaligned target; a trap never commits pc or instret.
            if (commit) begin
                if (!legal)
                    trap_cause <= 2'b01;
                else if (misaligned)
                    trap_cause <= 2'b10;
                else begin
                    pc      <= next_pc;
                    instret <= instret + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized instruction stream vs. a reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pc_plus4;
    logic        branch = 1'b0, jump = 1'b0, is_jalr = 1'b0;
    logic [31:0] imm = '0, alu_result = '0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic        stall = 1'b0;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instret = 32'h0;
    logic        exp_halted = 1'b0;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .jump(jump), .is_jalr(is_jalr), .imm(imm), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .stall(stall),
        .halted(halted), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: what the architectural rules say happens to an instruction at cur_pc.
    function automatic void model(input logic [31:0] cur_pc, input logic [31:0] w,
                                  input logic br, input logic jp, input logic jr,
                                  input logic [31:0] immv, input logic [31:0] aluv,
                                  input logic z, input logic lt, input logic ltu,
                                  output logic [31:0] npc, output logic [1:0] trap);
        logic [6:0] op;
        logic [2:0] f3;
        logic ok, tk;
        op = w[6:0];
        f3 = w[14:12];
        ok = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) ok = 1'b1;
        if (op == OP_BR && (f3 == 3'd2 || f3 == 3'd3)) ok = 1'b0;
        case (f3)
            3'd0: tk = z;
            3'd1: tk = !z;
            3'd4: tk = lt;
            3'd5: tk = !lt;
            3'd6: tk = ltu;
            3'd7: tk = !ltu;
            default: tk = 1'b0;
        endcase
        if (jp && jr)      npc = aluv & 32'hFFFF_FFFE;
        else if (jp)       npc = cur_pc + immv;
        else if (br && tk) npc = cur_pc + immv;
        else               npc = cur_pc + 32'd4;
        if (!ok)                  trap = 2'b01;
        else if (npc[1:0] != 0)   trap = 2'b10;
        else                      trap = 2'b00;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            trap_cause !== 2'b00 || instret !== 32'h0 || instr !== 32'h0000_0013)
            begin errors++; $display("FAIL reset_state: req=%b pc=%h vld=%b halt=%b trap=%b instret=%0d instr=%h required 0/0/0/0/00/0/00000013",
                                     imem_req, pc, instr_valid, halted, trap_cause, instret, instr); end
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b0;
        exp_pc = 32'h0; exp_instret = 32'h0; exp_halted = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] w, input int waits, input int stalls,
                            input logic br, input logic jp, input logic jr,
                            input logic [31:0] immv, input logic [31:0] aluv,
                            input logic z, input logic lt, input logic ltu);
        logic [31:0] npc;
        logic [1:0]  trap;
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req); return; end
        checks++;
        if (imem_addr !== exp_pc) begin errors++; $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_pc); end
        repeat (waits) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
                begin errors++; $display("FAIL wait_hold: req=%b addr=%h vld=%b required 1/%h/0", imem_req, imem_addr, instr_valid, exp_pc); end
        end
        imem_ready = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_ready = 1'b0; imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || instr !== w || imem_req !== 1'b0)
            begin errors++; $display("FAIL exec_entry: vld=%b instr=%h req=%b required 1/%h/0", instr_valid, instr, imem_req, w); end
        checks++;
        if ({funct7, rs2, rs1, funct3, rd, opcode} !== w)
            begin errors++; $display("FAIL fields: got %h required %h", {funct7, rs2, rs1, funct3, rd, opcode}, w); end
        checks++;
        if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL pc_plus4: got %h required %h", pc_plus4, exp_pc + 32'd4); end
        branch = br; jump = jp; is_jalr = jr; imm = immv; alu_result = aluv;
        alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        model(exp_pc, w, br, jp, jr, immv, aluv, z, lt, ltu, npc, trap);
        repeat (stalls) begin
            stall = 1'b1;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || pc !== exp_pc || instret !== exp_instret || halted !== 1'b0)
                begin errors++; $display("FAIL stall_hold: vld=%b pc=%h instret=%0d halt=%b required 1/%h/%0d/0",
                                         instr_valid, pc, instret, halted, exp_pc, exp_instret); end
        end
        stall = 1'b0;
        @(negedge clk);
        if (trap != 2'b00) begin
            exp_halted = 1'b1;
            checks++;
            if (halted !== 1'b1 || trap_cause !== trap || pc !== exp_pc || instret !== exp_instret ||
                imem_req !== 1'b0 || instr_valid !== 1'b0)
                begin errors++; $display("FAIL trap: halt=%b cause=%b pc=%h instret=%0d req=%b vld=%b required 1/%b/%h/%0d/0/0",
                                         halted, trap_cause, pc, instret, imem_req, instr_valid, trap, exp_pc, exp_instret); end
        end else begin
            exp_pc = npc;
            exp_instret = exp_instret + 32'd1;
            checks++;
            if (pc !== exp_pc || instret !== exp_instret || imem_req !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0)
                begin errors++; $display("FAIL retire: pc=%h instret=%0d req=%b vld=%b halt=%b required %h/%0d/1/0/0",
                                         pc, instret, imem_req, instr_valid, halted, exp_pc, exp_instret); end
        end
        branch = 1'b0; jump = 1'b0; is_jalr = 1'b0; imm = '0; alu_result = '0;
    endtask

    task automatic jal_to(input logic [31:0] target);
        do_instr({25'h0, OP_JAL}, 0, 0, 1'b0, 1'b1, 1'b0, target - exp_pc, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_addi();
        do_instr(32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rd !== 5'd1 || opcode !== OP_ADDI) begin errors++; $display("FAIL addi_fields: rd=%0d opcode=%b", rd, opcode); end
    endtask

    task automatic test_wait_states();
        do_instr(32'h0010_0113, 3, 0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        logic [31:0] beq, bne;
        beq = {25'h0, OP_BR};
        bne = {17'h0, 3'b001, 5'h0, OP_BR};
        jal_to(32'h10);
        do_instr(beq, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h08) begin errors++; $display("FAIL beq_taken: pc=%h required 00000008", pc); end
        jal_to(32'h10);
        do_instr(beq, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);
        jal_to(32'h10);
        do_instr(bne, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h14) begin errors++; $display("FAIL bne_not_taken: pc=%h required 00000014", pc); end
    endtask

    task automatic test_jumps();
        jal_to(32'h20);
        do_instr({25'h0, OP_JAL}, 0, 0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h120) begin errors++; $display("FAIL jal_target: pc=%h required 00000120", pc); end
        do_instr({25'h0, OP_JALR}, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0205, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h204) begin errors++; $display("FAIL jalr_target: pc=%h required 00000204", pc); end
    endtask

    task automatic test_stall();
        do_instr(32'h0050_0093, 0, 2, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
        // A JALR landing on 0x202 has bit1 set after alignment, so it must trap.
        do_instr({25'h0, OP_JALR}, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0203, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        do_reset();
        do_instr(32'h0000_007F, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        checks++;
        if (halted !== 1'b1 || trap_cause !== 2'b01 || imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0000_007F)
            begin errors++; $display("FAIL illegal_sticky: halt=%b cause=%b req=%b pc=%h instr=%h", halted, trap_cause, imem_req, pc, instr); end
    endtask

    task automatic test_misaligned();
        do_reset();
        jal_to(32'h10);
        do_instr({25'h0, OP_BR}, 0, 0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (trap_cause !== 2'b10 || pc !== 32'h10) begin errors++; $display("FAIL misaligned: cause=%b pc=%h required 10/00000010", trap_cause, pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        jal_to(32'hFFFF_FFFC);
        do_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: pc=%h required 00000000", pc); end
    endtask

    task automatic test_reset_mid_fetch();
        do_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_fetch: imem_req=%b required 1", imem_req); end
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL reset_mid_fetch: req=%b pc=%h required 0/00000000", imem_req, pc); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b0;
        exp_pc = 32'h0; exp_instret = 32'h0; exp_halted = 1'b0;
        checks++;
        if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin errors++; $display("FAIL late_ready_ignored: instr=%h vld=%b", instr, instr_valid); end
    endtask

    task automatic test_random();
        logic [31:0] r, r2, r3, w, immv, aluv;
        logic [6:0]  op;
        for (int k = 0; k < 250; k++) begin
            if (exp_halted) do_reset();
            r = $urandom; r2 = $urandom; r3 = $urandom;
            op = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = r[6:0];
            w = {r[31:7], op};
            immv = {r2[31:2], ($urandom_range(0, 7) == 0) ? r2[1:0] : 2'b00};
            aluv = {r3[31:2], ($urandom_range(0, 7) == 0) ? r3[1] : 1'b0, r3[0]};
            do_instr(w, $urandom_range(0, 2), $urandom_range(0, 2),
                     op == OP_BR, (op == OP_JAL) || (op == OP_JALR), op == OP_JALR,
                     immv, aluv, r3[0] ^ r2[0], r[7], r2[5]);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wait_states();
        test_branch();
        test_jumps();
        test_stall();
        test_illegal();
        test_misaligned();
        test_pc_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
